// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: parses HEADER/LEN/PAYLOAD/CSUM frames from a UART
// receiver byte stream, buffers good payloads and drains them over
// valid/ready. Bad frames produce a single-cycle error pulse.
// Optional inter-byte timeout is enabled with `define RX_TIMEOUT_EN.
module uart_rx_frame_ctrl #(
  parameter int          MAX_LEN        = 16,
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 4200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic [7:0] frame_len,
  output logic       frame_ok,
  output logic       err_checksum,
  output logic       err_length,
  output logic       err_overrun,
  output logic       err_timeout,
  output logic       busy
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("uart_rx_frame_ctrl: parameter out of range");
  end

  typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CSUM, DRAIN} state_t;

  state_t     state, state_nxt;
  logic       rx_done_q;
  logic       accept;
  logic       xfer;
  logic       len_bad;
  logic [7:0] count;
  logic [7:0] sum;
  logic [7:0] rd_ptr;
  logic [7:0] mem [MAX_LEN];
  logic       ok_nxt, ecs_nxt, elen_nxt, eovr_nxt;

  assign accept  = rx_done && !rx_done_q;
  assign len_bad = (rx_data == 8'd0) || (rx_data > 8'(MAX_LEN));

  assign busy      = (state != IDLE);
  assign out_valid = (state == DRAIN);
  assign out_data  = (state == DRAIN) ? mem[rd_ptr[AW-1:0]] : '0;
  assign out_last  = (state == DRAIN) && (rd_ptr == frame_len - 8'd1);
  assign xfer      = out_valid && out_ready;

`ifdef RX_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic        tmo_hit;
  logic        etmo_nxt;

  // An accepted byte in the limit cycle wins over the timeout.
  assign tmo_hit = (tmo_cnt == 32'(TIMEOUT_CYCLES - 1)) && !accept &&
                   (state == LEN || state == PAYLOAD || state == CSUM);

  // Inter-byte idle counter, active only while mid-frame.
  always_ff @(posedge clk) begin
    if (reset || accept || tmo_hit || state == IDLE || state == DRAIN)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + 32'd1;
  end

  // Registered timeout pulse.
  always_ff @(posedge clk) begin
    if (reset) err_timeout <= 1'b0;
    else       err_timeout <= etmo_nxt;
  end
`else
  assign err_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and error/ok pulse requests.
  always_comb begin
    state_nxt = state;
    ok_nxt    = 1'b0;
    ecs_nxt   = 1'b0;
    elen_nxt  = 1'b0;
    eovr_nxt  = 1'b0;
`ifdef RX_TIMEOUT_EN
    etmo_nxt  = 1'b0;
`endif
    case (state)
      IDLE: if (accept && rx_data == HEADER) state_nxt = LEN;
      LEN: begin
        if (accept) begin
          if (len_bad) begin
            elen_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = PAYLOAD;
          end
        end
      end
      PAYLOAD: if (accept && count == frame_len - 8'd1) state_nxt = CSUM;
      CSUM: begin
        if (accept) begin
          if (rx_data == sum) begin
            ok_nxt    = 1'b1;
            state_nxt = DRAIN;
          end else begin
            ecs_nxt   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      DRAIN: begin
        if (accept) eovr_nxt = 1'b1;
        if (xfer && out_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
`ifdef RX_TIMEOUT_EN
    if (tmo_hit) begin
      etmo_nxt  = 1'b1;
      state_nxt = IDLE;
    end
`endif
  end

  // Frame datapath: byte history, length, checksum, counters and pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_done_q    <= 1'b0;
      frame_len    <= '0;
      sum          <= '0;
      count        <= '0;
      rd_ptr       <= '0;
      frame_ok     <= 1'b0;
      err_checksum <= 1'b0;
      err_length   <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      rx_done_q    <= rx_done;
      frame_ok     <= ok_nxt;
      err_checksum <= ecs_nxt;
      err_length   <= elen_nxt;
      err_overrun  <= eovr_nxt;
      case (state)
        LEN: begin
          if (accept && !len_bad) begin
            frame_len <= rx_data;
            sum       <= rx_data;
            count     <= '0;
          end
        end
        PAYLOAD: begin
          if (accept) begin
            sum   <= sum + rx_data;
            count <= count + 8'd1;
          end
        end
        CSUM:  if (accept && rx_data == sum) rd_ptr <= '0;
        DRAIN: if (xfer) rd_ptr <= rd_ptr + 8'd1;
        default: ;
      endcase
    end
  end

  // Payload buffer write; contents need no reset.
  always_ff @(posedge clk) begin
    if (state == PAYLOAD && accept) mem[count[AW-1:0]] <= rx_data;
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed self-checking bench for uart_rx_frame_ctrl (default parameters).
module tb_uart_rx_frame_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = '0;
  logic       out_ready = 1'b1;
  logic       out_valid, out_last, frame_ok, busy;
  logic       err_checksum, err_length, err_overrun, err_timeout;
  logic [7:0] out_data, frame_len;

  int compared = 0;
  int mismatched = 0;

  int c_ok = 0, c_cs = 0, c_len = 0, c_ovr = 0, c_tmo = 0, c_valid = 0;
  logic [7:0] got_data[$];
  logic       got_last[$];

  uart_rx_frame_ctrl dut (
    .clk(clk), .reset(reset), .rx_done(rx_done), .rx_data(rx_data),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .frame_len(frame_len), .frame_ok(frame_ok),
    .err_checksum(err_checksum), .err_length(err_length),
    .err_overrun(err_overrun), .err_timeout(err_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  // Monitor samples mid-low-phase, after inputs driven at negedge settle.
  always begin
    @(negedge clk);
    #2;
    if (frame_ok)     c_ok++;
    if (err_checksum) c_cs++;
    if (err_length)   c_len++;
    if (err_overrun)  c_ovr++;
    if (err_timeout)  c_tmo++;
    if (out_valid)    c_valid++;
    if (out_valid && out_ready) begin
      got_data.push_back(out_data);
      got_last.push_back(out_last);
    end
  end

  // Packs count and first three drained bytes starting at index s.
  function automatic logic [31:0] drained(input int s);
    logic [31:0] r;
    int n;
    n = got_data.size() - s;
    r = {8'(n), 24'h0};
    for (int i = 0; i < 3; i++)
      if (i < n) r[23 - 8*i -: 8] = got_data[s + i];
    return r;
  endfunction

  function automatic logic [3:0] lasts(input int s);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 3; i++)
      if (s + i < got_last.size()) r[2 - i] = got_last[s + i];
    r[3] = (got_last.size() - s) > 3;
    return r;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge clk);
    rx_done = 1'b1;
    rx_data = b;
    repeat (hold) @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send_good(input int hold);
    send_byte(8'hA5, hold);
    send_byte(8'h03, hold);
    send_byte(8'h11, hold);
    send_byte(8'h22, hold);
    send_byte(8'h33, hold);
    send_byte(8'h69, hold);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    compared++;
    if ({out_valid, out_data, out_last, frame_len, frame_ok, err_checksum,
         err_length, err_overrun, err_timeout, busy} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got valid=%b data=%h last=%b len=%h ok=%b busy=%b, want all 0",
               out_valid, out_data, out_last, frame_len, frame_ok, busy);
    end
  endtask

  task automatic test_good_frame;
    int s, ok0;
    s = got_data.size();
    ok0 = c_ok;
    send_good(1);
    compared++;
    if ({frame_ok, out_valid} !== 2'b11) begin
      mismatched++;
      $display("FAIL good_latency: frame_ok,out_valid=%b want 11", {frame_ok, out_valid});
    end
    repeat (8) @(negedge clk);
    compared++;
    if (c_ok - ok0 !== 1) begin
      mismatched++;
      $display("FAIL good_ok_count: got %0d want 1", c_ok - ok0);
    end
    compared++;
    if (frame_len !== 8'd3) begin
      mismatched++;
      $display("FAIL good_frame_len: got %0d want 3", frame_len);
    end
    compared++;
    if (drained(s) !== 32'h03112233) begin
      mismatched++;
      $display("FAIL good_data: got %h want 03112233", drained(s));
    end
    compared++;
    if (lasts(s) !== 4'b0001) begin
      mismatched++;
      $display("FAIL good_last: got %b want 0001", lasts(s));
    end
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL good_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_bad_checksum;
    int cs0, v0, s;
    cs0 = c_cs;
    v0 = c_valid;
    send_byte(8'hA5, 1); send_byte(8'h03, 1); send_byte(8'h11, 1);
    send_byte(8'h22, 1); send_byte(8'h33, 1); send_byte(8'h68, 1);
    repeat (5) @(negedge clk);
    compared++;
    if (c_cs - cs0 !== 1) begin
      mismatched++;
      $display("FAIL badcs_pulse: got %0d want 1", c_cs - cs0);
    end
    compared++;
    if (c_valid - v0 !== 0) begin
      mismatched++;
      $display("FAIL badcs_no_valid: got %0d valid cycles want 0", c_valid - v0);
    end
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL badcs_busy: got %b want 0", busy);
    end
    s = got_data.size();
    send_good(1);
    repeat (8) @(negedge clk);
    compared++;
    if (drained(s) !== 32'h03112233) begin
      mismatched++;
      $display("FAIL badcs_recover: got %h want 03112233", drained(s));
    end
  endtask

  task automatic test_bad_length;
    int l0, others0;
    l0 = c_len;
    send_byte(8'hA5, 1); send_byte(8'h00, 1);
    repeat (3) @(negedge clk);
    compared++;
    if (c_len - l0 !== 1 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL badlen_zero: pulses=%0d busy=%b want 1,0", c_len - l0, busy);
    end
    send_byte(8'hA5, 1); send_byte(8'h11, 1);
    repeat (3) @(negedge clk);
    compared++;
    if (c_len - l0 !== 2 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL badlen_17: pulses=%0d busy=%b want 2,0", c_len - l0, busy);
    end
    others0 = c_ok + c_cs + c_len + c_ovr + c_tmo;
    send_byte(8'h5A, 1); send_byte(8'h00, 1);
    repeat (3) @(negedge clk);
    compared++;
    if ((c_ok + c_cs + c_len + c_ovr + c_tmo) - others0 !== 0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL stray_bytes: pulses=%0d busy=%b want 0,0",
               (c_ok + c_cs + c_len + c_ovr + c_tmo) - others0, busy);
    end
  endtask

  task automatic test_backpressure;
    int s, o0;
    logic held;
    s = got_data.size();
    o0 = c_ovr;
    @(negedge clk);
    out_ready = 1'b0;
    send_good(1);
    held = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!(out_valid === 1'b1 && out_data === 8'h11 && out_last === 1'b0)) held = 1'b0;
    end
    compared++;
    if (held !== 1'b1) begin
      mismatched++;
      $display("FAIL bp_hold: data=%h last=%b valid=%b want 11,0,1", out_data, out_last, out_valid);
    end
    send_byte(8'hA5, 1);
    repeat (2) @(negedge clk);
    compared++;
    if (c_ovr - o0 !== 1) begin
      mismatched++;
      $display("FAIL bp_overrun: got %0d want 1", c_ovr - o0);
    end
    compared++;
    if (busy !== 1'b1 || out_data !== 8'h11) begin
      mismatched++;
      $display("FAIL bp_still_drain: busy=%b data=%h want 1,11", busy, out_data);
    end
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    compared++;
    if (drained(s) !== 32'h03112233) begin
      mismatched++;
      $display("FAIL bp_data: got %h want 03112233", drained(s));
    end
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL bp_header_dropped: busy=%b want 0", busy);
    end
  endtask

  task automatic test_timeout;
    int t0, s;
    t0 = c_tmo;
    send_byte(8'hA5, 1); send_byte(8'h02, 1); send_byte(8'h11, 1);
    repeat (4300) @(negedge clk);
`ifdef RX_TIMEOUT_EN
    compared++;
    if (c_tmo - t0 !== 1 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL timeout_fire: pulses=%0d busy=%b want 1,0", c_tmo - t0, busy);
    end
`else
    compared++;
    if (c_tmo - t0 !== 0 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL timeout_off: pulses=%0d busy=%b want 0,1", c_tmo - t0, busy);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
`endif
    s = got_data.size();
    send_good(1);
    repeat (8) @(negedge clk);
    compared++;
    if (drained(s) !== 32'h03112233) begin
      mismatched++;
      $display("FAIL timeout_recover: got %h want 03112233", drained(s));
    end
  endtask

  task automatic test_robust;
    int s, ok0, e0;
    s = got_data.size();
    ok0 = c_ok;
    send_good(20);
    repeat (8) @(negedge clk);
    compared++;
    if (c_ok - ok0 !== 1 || drained(s) !== 32'h03112233) begin
      mismatched++;
      $display("FAIL long_rx_done: ok=%0d data=%h want 1,03112233", c_ok - ok0, drained(s));
    end
    e0 = c_cs + c_len + c_ovr + c_tmo;
    send_byte(8'hA5, 1); send_byte(8'h03, 1); send_byte(8'h11, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    compared++;
    if ({out_valid, out_data, out_last, frame_len, frame_ok, err_checksum,
         err_length, err_overrun, err_timeout, busy} !== '0) begin
      mismatched++;
      $display("FAIL midreset_outputs: valid=%b data=%h len=%h busy=%b want all 0",
               out_valid, out_data, frame_len, busy);
    end
    reset = 1'b0;
    s = got_data.size();
    send_good(1);
    repeat (8) @(negedge clk);
    compared++;
    if (drained(s) !== 32'h03112233 || (c_cs + c_len + c_ovr + c_tmo) - e0 !== 0) begin
      mismatched++;
      $display("FAIL midreset_recover: data=%h errs=%0d want 03112233,0",
               drained(s), (c_cs + c_len + c_ovr + c_tmo) - e0);
    end
  endtask

  initial begin
    test_reset;
    test_good_frame;
    test_bad_checksum;
    test_bad_length;
    test_backpressure;
    test_timeout;
    test_robust;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Framing controller that sits after the UART receiver and sequences its byte stream into validated packets. It watches the receiver's done strobe and data byte, and parses frames of the form header, length, payload, checksum. Good payloads are held in an internal buffer and streamed to a consumer over a valid/ready interface. Bad frames are discarded with an error pulse.

Parameters:
MAX_LEN, 16, maximum payload bytes per frame; legal range 1..255; sets the buffer depth.
HEADER, 8'hA5, start-of-frame byte.
TIMEOUT_CYCLES, 4200, inter-byte idle limit in clk cycles (about 2 byte times at 9600 baud on a 2 MHz clk); used only with RX_TIMEOUT_EN.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
rx_done  input  1  receiver byte-complete flag; may stay high for more than 1 cycle
rx_data  input  8  receiver data byte; valid while rx_done is high
out_valid  output  1  payload byte available
out_data  output  8  payload byte
out_last  output  1  high with the final payload byte of a frame
out_ready  input  1  consumer accepts the byte when out_valid && out_ready
frame_len  output  8  payload length of the frame being drained
frame_ok  output  1  1-cycle pulse: frame validated
err_checksum  output  1  1-cycle pulse
err_length  output  1  1-cycle pulse
err_overrun  output  1  1-cycle pulse
err_timeout  output  1  1-cycle pulse
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE; all outputs 0; byte counter, read pointer, checksum accumulator, timeout counter and rx_done history register all 0. Buffer contents are don't-care.
- Byte capture:
  - rx_done_q is a registered copy of rx_done.
  - A byte is accepted only in a cycle where rx_done && !rx_done_q, so each byte is accepted exactly once however long rx_done stays high.
  - rx_data is sampled in that same cycle.
- States: IDLE, LEN, PAYLOAD, CSUM, DRAIN.
- IDLE:
  - Accepted byte == HEADER goes to LEN.
  - Any other byte is ignored silently, with no error.
- LEN:
  - If the accepted byte L is 0 or greater than MAX_LEN: err_length pulse, go to IDLE.
  - Otherwise: frame_len<=L, sum<=L, count<=0, go to PAYLOAD.
- PAYLOAD:
  - Each accepted byte is written to buf[count], then sum<=sum+byte (mod 256) and count<=count+1.
  - When count reaches L-1 and that byte is accepted, go to CSUM.
- CSUM:
  - If the accepted byte == sum: frame_ok pulse, rd_ptr<=0, go to DRAIN.
  - Otherwise: err_checksum pulse, go to IDLE. No out_valid is ever raised for a bad frame.
- Latency: frame_ok and the first out_valid are both high in the cycle after the checksum byte is accepted.
- DRAIN:
  - out_valid=1; out_data=buf[rd_ptr]; out_last=(rd_ptr==frame_len-1).
  - On out_valid&&out_ready, rd_ptr increments. The transfer where out_last is high returns to IDLE, and out_valid falls the next cycle.
  - While out_ready=0, out_data and out_last must hold stable.
  - Any byte accepted during DRAIN is dropped: err_overrun pulse, no state change, and the byte is not parsed (even if it equals HEADER).
- frame_len holds its value until the next valid LEN byte.
- Simultaneous events: a byte acceptance and an output transfer in the same cycle are both honoured. Only one error pulse can occur per cycle.
- Reset mid-operation: immediate return to IDLE. Any partial or undrained frame is lost, and no error pulse is raised.
- Checksum arithmetic is 8-bit wrap-around over LEN plus all payload bytes. The HEADER byte is excluded.

Optional Feature:
RX_TIMEOUT_EN
- Defined:
  - In LEN, PAYLOAD and CSUM, a counter increments every cycle and clears on each accepted byte.
  - When it reaches TIMEOUT_CYCLES-1: err_timeout pulse, go to IDLE, counter cleared.
  - The counter is held at 0 in IDLE and DRAIN.
- Not defined: no counter logic is present, err_timeout is tied 0, and the parser waits indefinitely for the next byte.

Test Plan:
1. Good frame (MAX_LEN=16), bytes A5 03 11 22 33 69 -> frame_ok pulse once; frame_len=3; out_data 11,22,33 with out_ready=1; out_last only on 33; then busy=0.
2. Bad checksum A5 03 11 22 33 68 -> err_checksum pulse; out_valid never high. A following good frame from test 1 is delivered normally.
3. Bad length: A5 00 -> err_length. Then A5 11 -> err_length. Then stray bytes 5A 00 -> no pulses, state stays IDLE.
4. Backpressure and overrun: good frame, then hold out_ready=0 for 5 cycles -> out_data=11 stable. Inject A5 during DRAIN -> err_overrun pulse; A5 is not parsed; the drain completes with all 3 bytes.
5. Timeout (macro defined): A5 02 11, then no rx_done for 4200 cycles -> err_timeout pulse, busy=0; the next good frame is accepted. With the macro undefined -> busy stays 1 and no pulse.
6. Robustness: hold rx_done high 20 cycles per byte -> each byte counted once. Assert reset mid-PAYLOAD -> all outputs 0 the next cycle, and a subsequent good frame is delivered correctly.
